// File: rtl/ladybird_fetch_unit.sv
// ladybird_fetch_unit: multi-outstanding instruction fetch front end with FIFO.
// Define LADYBIRD_FETCH_PERF_EN to add saturating perf counter outputs.
module ladybird_fetch_unit #(
  parameter int XLEN            = 32,
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic [XLEN-1:0] start_pc,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mem_pc,
  output logic            mem_pc_valid,
  input  logic            mem_pc_ready,
  input  logic [XLEN-1:0] mem_inst,
  input  logic            mem_inst_valid,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            idle
`ifdef LADYBIRD_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall
`endif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] fetch_pc, next_pc;
  logic [XLEN-1:0] q_inst [QUEUE_DEPTH];
  logic [XLEN-1:0] q_pc [QUEUE_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [OW-1:0]   outst, outst_nxt, drop_cnt;
  logic [CW:0]     used;
  logic [XLEN-1:0] redir_pc;
  logic            run, flush, issue;
  logic            drop, push, pop, clear;

  assign run      = (state == S_RUN);
  assign flush    = run & redirect_valid;
  assign redir_pc = redirect_pc & ~XLEN'(3);
  // In-flight fetches reserve a queue slot so a push can never overflow
  assign used     = {1'b0, count} + (CW+1)'(outst);

  assign mem_pc       = fetch_pc;
  assign mem_pc_valid = run & ~halt & ~redirect_valid
                      & (outst < OW'(MAX_OUTSTANDING))
                      & (used < (CW+1)'(QUEUE_DEPTH));
  assign issue        = mem_pc_valid & mem_pc_ready;

  assign drop = mem_inst_valid & (flush | (drop_cnt != '0));
  assign push = mem_inst_valid & ~drop;

  assign out_valid = (count != '0) & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign out_inst  = q_inst[rd_ptr];
  assign out_pc    = q_pc[rd_ptr];

  assign outst_nxt = outst + OW'(issue) - OW'(mem_inst_valid);
  assign clear     = flush
                   | ((state == S_HALT) & (state_nxt == S_IDLE));
  assign idle      = (state == S_IDLE) & (count == '0)
                   & (outst == '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (halt) state_nxt = S_HALT;
      S_HALT:  if (outst_nxt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_IDLE;
      fetch_pc <= '0;
      next_pc  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      outst    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      state <= state_nxt;
      outst <= outst_nxt;
      if (state == S_IDLE && start) begin
        fetch_pc <= start_pc;
        next_pc  <= start_pc;
      end else if (flush) begin
        fetch_pc <= redir_pc;
        next_pc  <= redir_pc;
      end else begin
        if (issue) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)  next_pc  <= next_pc + XLEN'(4);
      end
      // Everything still in flight at a redirect belongs to the old path
      if (flush)
        drop_cnt <= outst - OW'(mem_inst_valid);
      else if (mem_inst_valid && drop_cnt != '0)
        drop_cnt <= drop_cnt - OW'(1);
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          q_inst[wr_ptr] <= mem_inst;
          q_pc[wr_ptr]   <= next_pc;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst)
      assert (!(push && !clear && count == CW'(QUEUE_DEPTH)));
  end

`ifdef LADYBIRD_FETCH_PERF_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      if (drop && perf_dropped != '1)
        perf_dropped <= perf_dropped + 32'd1;
      if (run && !out_valid && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ladybird_fetch_unit.sv
// tb_ladybird_fetch_unit: directed bench with a latency-programmable MMU model.
module tb_ladybird_fetch_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [31:0] start_pc;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_pc;
  logic        mem_pc_valid;
  logic        mem_pc_ready;
  logic [31:0] mem_inst = '0;
  logic        mem_inst_valid = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        idle;
`ifdef LADYBIRD_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

  always #5 clk = ~clk;

  ladybird_fetch_unit dut (
    .clk(clk),
    .nrst(nrst),
    .start(start),
    .start_pc(start_pc),
    .halt(halt),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .mem_pc(mem_pc),
    .mem_pc_valid(mem_pc_valid),
    .mem_pc_ready(mem_pc_ready),
    .mem_inst(mem_inst),
    .mem_inst_valid(mem_inst_valid),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .idle(idle)
`ifdef LADYBIRD_FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped),
    .perf_stall(perf_stall)
`endif
  );

  typedef struct {
    logic [31:0] a;
    int          due;
  } req_t;

  int          cyc = 0;
  req_t        pend[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  int          pop_cyc[$];
  int          lat = 1;
  bit          resp_en = 1'b1;
  int          inflight = 0;
  int          max_inflight = 0;
  int          resp_cyc = 0;
  int          passed = 0;
  int          failed = 0;
  int          total = 0;
  bit          found;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return ~a + 32'h1357_0000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // MMU: accepts sampled mid-cycle, responses driven just after the edge
  always @(negedge clk) begin
    if (nrst && mem_pc_valid && mem_pc_ready) begin
      pend.push_back('{mem_pc, cyc + lat});
      acc_addr.push_back(mem_pc);
      acc_cyc.push_back(cyc);
      inflight++;
      if (inflight > max_inflight) max_inflight = inflight;
    end
    if (nrst && out_valid && out_ready) begin
      pop_pc.push_back(out_pc);
      pop_inst.push_back(out_inst);
      pop_cyc.push_back(cyc);
    end
  end

  always begin
    @(posedge clk);
    #1;
    mem_inst_valid = 1'b0;
    if (nrst && resp_en && pend.size() > 0) begin
      if (pend[0].due <= cyc) begin
        mem_inst_valid = 1'b1;
        mem_inst = word_of(pend[0].a);
        void'(pend.pop_front());
        inflight--;
        resp_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    pend.delete();
    acc_addr.delete();
    acc_cyc.delete();
    pop_pc.delete();
    pop_inst.delete();
    pop_cyc.delete();
    inflight = 0;
    max_inflight = 0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic go(input logic [31:0] pc);
    start_pc = pc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int i = 0; i < budget && pop_pc.size() < n; i++) tick();
    chk("pop_budget", 32'(pop_pc.size() >= n), 32'd1);
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0;
    start_pc = '0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_pc_ready = 1'b1;
    out_ready = 1'b1;
    #2;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_pc_valid", 32'(mem_pc_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    tick();
    nrst = 1'b1;
    tick();

    // streaming, 1-cycle MMU
    lat = 1;
    go(32'h1000);
    wait_pops(3, 20);
    repeat (6) tick();
    chk("t1_pc0", pop_pc[0], 32'h1000);
    chk("t1_pc1", pop_pc[1], 32'h1004);
    chk("t1_pc2", pop_pc[2], 32'h1008);
    chk("t1_inst0", pop_inst[0], word_of(32'h1000));
    chk("t1_inst2", pop_inst[2], word_of(32'h1008));
    chk("t1_latency", 32'(pop_cyc[0] - acc_cyc[0]), 32'd2);
    chk("t1_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
    chk("t1_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
    chk("t1_inflight_le2", 32'(max_inflight <= 2), 32'd1);

    // slow MMU saturates the outstanding limit
    do_reset();
    lat = 3;
    go(32'h1000);
    repeat (15) tick();
    chk("t1b_max_inflight", 32'(max_inflight), 32'd2);
    chk("t1b_pc0", pop_pc[0], 32'h1000);
    chk("t1b_inst1", pop_inst[1], word_of(32'h1004));

    // decode stalled: queue fills to depth, then drains in order
    do_reset();
    lat = 1;
    out_ready = 1'b0;
    go(32'h1000);
    repeat (12) tick();
    chk("t2_accepts", 32'(acc_addr.size()), 32'd4);
    chk("t2_mem_pc_valid", 32'(mem_pc_valid), 32'd0);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_head_pc", out_pc, 32'h1000);
    out_ready = 1'b1;
    wait_pops(5, 20);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_drain%0d", i), pop_pc[i], 32'h1000 + 32'(4 * i));
    chk("t2_drain_inst3", pop_inst[3], word_of(32'h100C));
    chk("t2_resume_addr", acc_addr[4], 32'h1010);
    chk("t2_resume_pop", pop_pc[4], 32'h1010);

    // redirect with two fetches in flight
    do_reset();
    lat = 1;
    resp_en = 1'b0;
    mem_pc_ready = 1'b0;
    go(32'h2000);
    chk("t3_hold_valid0", 32'(mem_pc_valid), 32'd1);
    chk("t3_hold_pc0", mem_pc, 32'h2000);
    tick();
    chk("t3_hold_valid1", 32'(mem_pc_valid), 32'd1);
    chk("t3_hold_pc1", mem_pc, 32'h2000);
    mem_pc_ready = 1'b1;
    repeat (4) tick();
    chk("t3_accepts", 32'(acc_addr.size()), 32'd2);
    chk("t3_second_addr", acc_addr[1], 32'h2004);
    chk("t3_credit_stop", 32'(mem_pc_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3002;
    tick();
    redirect_valid = 1'b0;
    resp_en = 1'b1;
    wait_pops(1, 20);
    chk("t3_new_addr", acc_addr[2], 32'h3000);
    chk("t3_pc", pop_pc[0], 32'h3000);
    chk("t3_inst", pop_inst[0], word_of(32'h3000));
`ifdef LADYBIRD_FETCH_PERF_EN
    chk("t3_perf_dropped", perf_dropped, 32'd2);
`endif

    // redirect in the same cycle as a response, queue non-empty
    do_reset();
    lat = 3;
    out_ready = 1'b0;
    go(32'h4000);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (out_valid && mem_inst_valid && inflight == 1) found = 1'b1;
      else tick();
    end
    chk("t4_found", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h5000;
    #1;
    chk("t4_out_valid_low", 32'(out_valid), 32'd0);
    chk("t4_mem_valid_low", 32'(mem_pc_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    wait_pops(1, 30);
    chk("t4_pc", pop_pc[0], 32'h5000);
    chk("t4_inst", pop_inst[0], word_of(32'h5000));

    // halt with one fetch outstanding
    do_reset();
    lat = 1;
    resp_en = 1'b0;
    out_ready = 1'b0;
    go(32'h6000);
    tick();
    chk("t5_accepts", 32'(acc_addr.size()), 32'd1);
    halt = 1'b1;
    #1;
    chk("t5_no_issue", 32'(mem_pc_valid), 32'd0);
    tick();
    halt = 1'b0;
    tick();
    tick();
    chk("t5_halt_no_issue", 32'(mem_pc_valid), 32'd0);
    chk("t5_not_idle", 32'(idle), 32'd0);
    resp_en = 1'b1;
    for (int i = 0; i < 10 && !idle; i++) tick();
    chk("t5_idle", 32'(idle), 32'd1);
    chk("t5_idle_latency", 32'(cyc - resp_cyc), 32'd1);
    chk("t5_discarded", 32'(out_valid), 32'd0);
    chk("t5_accepts_final", 32'(acc_addr.size()), 32'd1);

    // pc wraps past the top of the address space
    do_reset();
    lat = 1;
    out_ready = 1'b1;
    go(32'hFFFF_FFF8);
    wait_pops(3, 20);
    chk("t6_wrap_addr", acc_addr[2], 32'h0000_0000);
    chk("t6_pc0", pop_pc[0], 32'hFFFF_FFF8);
    chk("t6_pc1", pop_pc[1], 32'hFFFF_FFFC);
    chk("t6_pc2", pop_pc[2], 32'h0000_0000);
    chk("t6_inst2", pop_inst[2], word_of(32'h0000_0000));

    // asynchronous reset mid-stream
    chk("t7_pre_valid", 32'(out_valid), 32'd1);
    nrst = 1'b0;
    #1;
    chk("t7_out_valid", 32'(out_valid), 32'd0);
    chk("t7_mem_pc_valid", 32'(mem_pc_valid), 32'd0);
    chk("t7_idle", 32'(idle), 32'd1);
    chk("t7_out_pc", out_pc, 32'd0);
    tick();
    nrst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
